// File: rtl/reservation_pool.sv
// reservation_pool: dispatch/wakeup/issue pool for one execution unit.
//
// Entries are written at the lowest free index, wait on up to two source
// tags, capture operand data from the CDB channels, and are moved into a
// single output register once both operands are present. The output
// register holds while the execution unit stalls.
//
// Optional feature macro: RS_AGE_ORDER_EN
//   defined   -> oldest ready entry (dispatch order, DEPTH x DEPTH age matrix)
//   undefined -> lowest-index ready entry, no age storage
//
// Ports:
//   clk, rst (synchronous, active-low), flush (mispredict)
//   in_valid/in_ready, in_op, in_Qj/in_Qk, in_Vj/in_Vk, in_imm, in_pc,
//     in_rob, in_has_rd           : dispatch interface
//   cdb_valid/cdb_tag/cdb_data    : NCDB packed broadcast channels, ch0 in LSBs
//   out_valid/out_ready, out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob
//                                 : issue register
//   free_count                    : number of non-busy entries
module reservation_pool #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int OPW   = 6,
  parameter int NCDB  = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_op,
  input  logic [TW-1:0]        in_Qj,
  input  logic [TW-1:0]        in_Qk,
  input  logic [DW-1:0]        in_Vj,
  input  logic [DW-1:0]        in_Vk,
  input  logic [DW-1:0]        in_imm,
  input  logic [DW-1:0]        in_pc,
  input  logic [TW-1:0]        in_rob,
  input  logic                 in_has_rd,
  input  logic [NCDB-1:0]      cdb_valid,
  input  logic [NCDB*TW-1:0]   cdb_tag,
  input  logic [NCDB*DW-1:0]   cdb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPW-1:0]       out_op,
  output logic [DW-1:0]        out_Vj,
  output logic [DW-1:0]        out_Vk,
  output logic [DW-1:0]        out_imm,
  output logic [DW-1:0]        out_pc,
  output logic [TW-1:0]        out_rob,
  output logic [CW-1:0]        free_count
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [OPW-1:0]   e_op  [DEPTH];
  logic [TW-1:0]    e_qj  [DEPTH];
  logic [TW-1:0]    e_qk  [DEPTH];
  logic [DW-1:0]    e_vj  [DEPTH];
  logic [DW-1:0]    e_vk  [DEPTH];
  logic [DW-1:0]    e_imm [DEPTH];
  logic [DW-1:0]    e_pc  [DEPTH];
  logic [TW-1:0]    e_rob [DEPTH];

  logic [DEPTH-1:0] wj_hit, wk_hit, rdy;
  logic [DW-1:0]    wj_data [DEPTH];
  logic [DW-1:0]    wk_data [DEPTH];
  logic             dj_hit, dk_hit;
  logic [DW-1:0]    dj_data, dk_data;

  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic             load_en, do_issue, do_dispatch;
  logic [CW-1:0]    free_cnt;

  // Returns {hit, data}. Channels are scanned high to low so the
  // lowest-index matching channel overwrites last and wins. Tag 0 never hits.
  function automatic logic [DW:0] cdb_hit(input logic [TW-1:0]      tag,
                                          input logic [NCDB-1:0]    v,
                                          input logic [NCDB*TW-1:0] t,
                                          input logic [NCDB*DW-1:0] d);
    logic [DW:0] r;
    r = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (v[c] && (tag != '0) && (t[c*TW +: TW] == tag))
        r = {1'b1, d[c*DW +: DW]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wj_hit[i], wj_data[i]} = cdb_hit(e_qj[i], cdb_valid, cdb_tag, cdb_data);
      {wk_hit[i], wk_data[i]} = cdb_hit(e_qk[i], cdb_valid, cdb_tag, cdb_data);
      rdy[i] = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
    end
    {dj_hit, dj_data} = cdb_hit(in_Qj, cdb_valid, cdb_tag, cdb_data);
    {dk_hit, dk_data} = cdb_hit(in_Qk, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    free_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
        free_cnt = free_cnt + 1'b1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age[j][i] = 1 means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] older_rdy;

  always_comb begin
    older_rdy = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if ((j != i) && rdy[j] && age[j][i]) older_rdy[i] = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i] && !older_rdy[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // A new entry is younger than everything; stale bits for idle entries
  // are overwritten when those entries are dispatched.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (do_dispatch) begin
      for (int i = 0; i < DEPTH; i++) begin
        age[free_idx][i] <= 1'b0;
        age[i][free_idx] <= (i != int'(free_idx));
      end
    end
  end
`else
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`endif

  assign in_ready    = rst && !flush && free_any;
  assign free_count  = rst ? free_cnt : CW'(DEPTH);
  assign load_en     = !out_valid || out_ready;
  assign do_issue    = load_en && sel_valid;
  assign do_dispatch = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_Vj    <= '0;
      out_Vk    <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_rob   <= '0;
    end else if (flush) begin
      busy      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (do_issue) begin
        busy[sel_idx] <= 1'b0;
        out_valid     <= 1'b1;
        out_op        <= e_op[sel_idx];
        out_Vj        <= e_vj[sel_idx];
        out_Vk        <= e_vk[sel_idx];
        out_imm       <= e_imm[sel_idx];
        out_pc        <= e_pc[sel_idx];
        out_rob       <= e_rob[sel_idx];
      end else if (load_en) begin
        out_valid <= 1'b0;
      end
      // free_idx is never busy, so it cannot collide with sel_idx
      if (do_dispatch) busy[free_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: busy qualifies every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wj_hit[i]) begin
        e_qj[i] <= '0;
        e_vj[i] <= wj_data[i];
      end
      if (wk_hit[i]) begin
        e_qk[i] <= '0;
        e_vk[i] <= wk_data[i];
      end
    end
    if (do_dispatch) begin
      e_op[free_idx]  <= in_op;
      e_qj[free_idx]  <= dj_hit ? '0 : in_Qj;
      e_vj[free_idx]  <= dj_hit ? dj_data : in_Vj;
      e_qk[free_idx]  <= dk_hit ? '0 : in_Qk;
      e_vk[free_idx]  <= dk_hit ? dk_data : in_Vk;
      e_imm[free_idx] <= in_imm;
      e_pc[free_idx]  <= in_pc;
      e_rob[free_idx] <= in_has_rd ? in_rob : '0;
    end
  end

endmodule

// File: tb/tb_reservation_pool.sv
module tb_reservation_pool;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_has_rd;
  logic [5:0]  in_op;
  logic [3:0]  in_Qj, in_Qk, in_rob;
  logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        out_valid, out_ready;
  logic [5:0]  out_op;
  logic [31:0] out_Vj, out_Vk, out_imm, out_pc;
  logic [3:0]  out_rob;
  logic [3:0]  free_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reservation_pool dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_Qj(in_Qj), .in_Qk(in_Qk), .in_Vj(in_Vj), .in_Vk(in_Vk),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob), .in_has_rd(in_has_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_Vj(out_Vj), .out_Vk(out_Vk), .out_imm(out_imm), .out_pc(out_pc),
    .out_rob(out_rob), .free_count(free_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] rob, input logic has_rd);
    in_valid  = 1'b1;
    in_op     = op;
    in_Qj     = qj;
    in_Qk     = qk;
    in_Vj     = vj;
    in_Vk     = vk;
    in_imm    = {26'd0, op} + 32'h1000;
    in_pc     = {26'd0, op} + 32'h4000;
    in_rob    = rob;
    in_has_rd = has_rd;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; clear_cdb();
    set_disp(6'h01, 4'd0, 4'd0, 32'h1, 32'h2, 4'd1, 1'b1);
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0d exp=0", in_ready); end
    total++; if (free_count !== 4'd8) begin bad++; $display("FAIL rst_free_count got=%0d exp=8", free_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
    total++; if (out_Vj !== 32'd0 || out_op !== 6'd0) begin bad++; $display("FAIL rst_out_data got=%h/%h exp=0/0", out_Vj, out_op); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    total++; if (free_count !== 4'd8) begin bad++; $display("FAIL rst_release_free got=%0d exp=8", free_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_disp(6'd3, 4'd0, 4'd0, 32'd5, 32'd7, 4'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    total++; if (free_count !== 4'd7) begin bad++; $display("FAIL basic_free1 got=%0d exp=7", free_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0d exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d exp=1", out_valid); end
    total++; if (out_op !== 6'd3 || out_Vj !== 32'd5 || out_Vk !== 32'd7) begin bad++; $display("FAIL basic_fields got=%0d/%0d/%0d exp=3/5/7", out_op, out_Vj, out_Vk); end
    total++; if (out_imm !== 32'h1003 || out_pc !== 32'h4003 || out_rob !== 4'd9) begin bad++; $display("FAIL basic_meta got=%h/%h/%0d exp=1003/4003/9", out_imm, out_pc, out_rob); end
    total++; if (free_count !== 4'd8) begin bad++; $display("FAIL basic_free2 got=%0d exp=8", free_count); end
    set_disp(6'd4, 4'd0, 4'd0, 32'd1, 32'd2, 4'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_op !== 6'd4 || out_rob !== 4'd0) begin bad++; $display("FAIL no_rd_rob got=%0d/%0d/%0d exp=1/4/0", out_valid, out_op, out_rob); end
    tick();
  endtask

  task automatic test_cdb_bypass();
    out_ready = 1'b1;
    set_disp(6'd5, 4'd4, 4'd0, 32'd0, 32'd1, 4'd2, 1'b1);
    cdb_valid = 2'b10; cdb_tag = {4'd4, 4'd0}; cdb_data = {32'h99, 32'h0};
    tick();
    in_valid = 1'b0; clear_cdb();
    tick();
    total++; if (out_valid !== 1'b1 || out_op !== 6'd5) begin bad++; $display("FAIL bypass_valid got=%0d/%0d exp=1/5", out_valid, out_op); end
    total++; if (out_Vj !== 32'h99 || out_Vk !== 32'd1) begin bad++; $display("FAIL bypass_data got=%h/%h exp=99/1", out_Vj, out_Vk); end
    tick();
  endtask

  task automatic test_cdb_priority();
    out_ready = 1'b1;
    set_disp(6'd6, 4'd2, 4'd0, 32'd0, 32'd3, 4'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || free_count !== 4'd7) begin bad++; $display("FAIL prio_wait got=%0d/%0d exp=0/7", out_valid, free_count); end
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_data = {32'h22, 32'h11};
    tick();
    clear_cdb();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_wake_delay got=%0d exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_Vj !== 32'h11 || out_Vk !== 32'd3) begin bad++; $display("FAIL prio_data got=%0d/%h/%h exp=1/11/3", out_valid, out_Vj, out_Vk); end
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_disp(6'(i + 1), 4'd6, 4'd0, 32'd0, 32'(i), 4'(i + 1), 1'b1);
      tick();
    end
    set_disp(6'h3F, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, 4'd15, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0 || free_count !== 4'd0) begin bad++; $display("FAIL fill_full got=%0d/%0d exp=0/0", in_ready, free_count); end
    tick();
    in_valid = 1'b0;
    total++; if (free_count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL fill_ninth got=%0d/%0d exp=0/0", free_count, out_valid); end
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd6}; cdb_data = {32'h0, 32'hAB};
    tick();
    clear_cdb();
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_op !== 6'(k + 1) || out_Vj !== 32'hAB || out_Vk !== 32'(k)) begin bad++; $display("FAIL fill_issue%0d got=%0d/%0d/%h/%0d exp=1/%0d/ab/%0d", k, out_valid, out_op, out_Vj, out_Vk, k + 1, k); end
      total++; if (free_count !== 4'(k + 1)) begin bad++; $display("FAIL fill_free%0d got=%0d exp=%0d", k, free_count, k + 1); end
    end
    tick();
    total++; if (out_valid !== 1'b0 || free_count !== 4'd8) begin bad++; $display("FAIL fill_end got=%0d/%0d exp=0/8", out_valid, free_count); end
  endtask

  task automatic test_hold_flush();
    out_ready = 1'b0;
    set_disp(6'h21, 4'd0, 4'd0, 32'h1234, 32'h5678, 4'd3, 1'b1);
    tick();
    set_disp(6'h22, 4'd0, 4'd0, 32'h1, 32'h2, 4'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_op !== 6'h21 || free_count !== 4'd7) begin bad++; $display("FAIL hold_load got=%0d/%h/%0d exp=1/21/7", out_valid, out_op, free_count); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_op !== 6'h21 || out_Vj !== 32'h1234 || out_Vk !== 32'h5678 || out_rob !== 4'd3) begin bad++; $display("FAIL hold_stable%0d got=%0d/%h/%h/%h/%0d exp=1/21/1234/5678/3", c, out_valid, out_op, out_Vj, out_Vk, out_rob); end
      total++; if (free_count !== 4'd7) begin bad++; $display("FAIL hold_free%0d got=%0d exp=7", c, free_count); end
    end
    flush = 1'b1;
    set_disp(6'h23, 4'd0, 4'd0, 32'h3, 32'h4, 4'd5, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0d exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || free_count !== 4'd8) begin bad++; $display("FAIL flush_clear got=%0d/%0d exp=0/8", out_valid, free_count); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stays got=%0d exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_disp(6'h30, 4'd0, 4'd0, 32'h5, 32'h6, 4'd1, 1'b1);
    tick();
    for (int i = 1; i < 6; i++) begin
      set_disp(6'(6'h30 + i), 4'd5, 4'd0, 32'd0, 32'd0, 4'(i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    total++; if (free_count !== 4'd3 || out_valid !== 1'b1 || out_op !== 6'h30) begin bad++; $display("FAIL mid_pre got=%0d/%0d/%h exp=3/1/30", free_count, out_valid, out_op); end
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || out_op !== 6'd0 || out_Vj !== 32'd0 || free_count !== 4'd8 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%h/%h/%0d/%0d exp=0/0/0/8/0", out_valid, out_op, out_Vj, free_count, in_ready); end
    rst = 1'b1; out_ready = 1'b1;
    set_disp(6'h2A, 4'd0, 4'd0, 32'h77, 32'h0, 4'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_op !== 6'h2A || out_Vj !== 32'h77 || free_count !== 4'd8) begin bad++; $display("FAIL mid_after got=%0d/%h/%h/%0d exp=1/2a/77/8", out_valid, out_op, out_Vj, free_count); end
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_data = {32'h0, 32'h55};
    tick();
    clear_cdb();
    tick();
    total++; if (out_valid !== 1'b0 || free_count !== 4'd8) begin bad++; $display("FAIL mid_no_ghost got=%0d/%0d exp=0/8", out_valid, free_count); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_Qj = '0; in_Qk = '0; in_Vj = '0; in_Vk = '0;
    in_imm = '0; in_pc = '0; in_rob = '0; in_has_rd = 1'b0;
    clear_cdb();
    test_reset();
    test_basic();
    test_cdb_bypass();
    test_cdb_priority();
    test_fill();
    test_hold_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
